// File: rtl/kr580_mem_arb.sv
// Single-port RAM arbiter between the KR580 CPU and the video fetcher: one slot per clock, video first, CPU starvation bounded by VMAX.
// Optional stall statistics counter enabled by defining KR580_ARB_STATS_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// GS_IDLE  | nobody owns the slot; CPU address on the bus, no write
// GS_CPU   | CPU owns the slot (locked=1); its write, if any, lands now
// GS_VID   | video owns the slot (vgnt=1); vaddr drives the RAM
module kr580_mem_arb #(
    parameter int VMAX = 4,
    parameter int AW   = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_out,
    output logic [7:0]    cpu_in,
    output logic          locked,
    input  logic          vreq,
    input  logic [AW-1:0] vaddr,
    output logic          vgnt,
    output logic          vvalid,
    output logic [7:0]    vdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_we,
    output logic [7:0]    mem_out,
    input  logic [7:0]    mem_in
`ifdef KR580_ARB_STATS_EN
    ,
    output logic [15:0]   stall_cnt,
    input  logic          stall_clr
`endif
);

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_CPU  = 2'd1,
        GS_VID  = 2'd2
    } gs_t;

    localparam logic [3:0] VMAX_C = 4'(VMAX);

    gs_t        r_gs;
    logic [3:0] r_vrun;
    logic       r_vpend;
    logic       r_vvalid;
    logic [7:0] r_vdata;

    logic       w_vid_win;
    logic       w_vrun_sat;

    // Video keeps the slot unless the CPU is waiting and the run budget is spent.
    assign w_vid_win  = vreq && !(cpu_req && (r_vrun == VMAX_C));
    assign w_vrun_sat = (r_vrun >= VMAX_C);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gs     <= GS_IDLE;
            r_vrun   <= 4'd0;
            r_vpend  <= 1'b0;
            r_vvalid <= 1'b0;
            r_vdata  <= 8'h00;
        end else begin
            if (w_vid_win) begin
                r_gs   <= GS_VID;
                r_vrun <= w_vrun_sat ? VMAX_C : (r_vrun + 4'd1);
            end else if (cpu_req) begin
                r_gs   <= GS_CPU;
                r_vrun <= 4'd0;
            end else begin
                r_gs   <= GS_IDLE;
                r_vrun <= 4'd0;
            end
            // RAM output lags the address by one clock, so capture one clock after the grant.
            r_vpend  <= (r_gs == GS_VID);
            r_vvalid <= r_vpend;
            if (r_vpend) begin
                r_vdata <= mem_in;
            end
        end
    end

    assign locked      = (r_gs == GS_CPU);
    assign vgnt        = (r_gs == GS_VID);
    assign mem_address = vgnt ? vaddr : cpu_address;
    assign mem_we      = locked & cpu_we;
    assign mem_out     = cpu_out;
    assign cpu_in      = mem_in;
    assign vvalid      = r_vvalid;
    assign vdata       = r_vdata;

`ifdef KR580_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (stall_clr) begin
            r_stall_cnt <= 16'h0000;
        end else if (cpu_req && !locked && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_kr580_mem_arb.sv
// Directed-vector bench for kr580_mem_arb with a scoreboard for video read data.
// Define KR580_ARB_STATS_EN to also exercise the stall counter.
module tb_kr580_mem_arb;

    logic        clock;
    logic        reset_n;
    logic        cpu_req;
    logic [15:0] cpu_address;
    logic        cpu_we;
    logic [7:0]  cpu_out;
    logic [7:0]  cpu_in;
    logic        locked;
    logic        vreq;
    logic [15:0] vaddr;
    logic        vgnt;
    logic        vvalid;
    logic [7:0]  vdata;
    logic [15:0] mem_address;
    logic        mem_we;
    logic [7:0]  mem_out;
    logic [7:0]  mem_in;
`ifdef KR580_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic        stall_clr;
    logic        nxt_clr;
`endif

    kr580_mem_arb #(.VMAX(4), .AW(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_address (cpu_address),
        .cpu_we      (cpu_we),
        .cpu_out     (cpu_out),
        .cpu_in      (cpu_in),
        .locked      (locked),
        .vreq        (vreq),
        .vaddr       (vaddr),
        .vgnt        (vgnt),
        .vvalid      (vvalid),
        .vdata       (vdata),
        .mem_address (mem_address),
        .mem_we      (mem_we),
        .mem_out     (mem_out),
        .mem_in      (mem_in)
`ifdef KR580_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .stall_clr   (stall_clr)
`endif
    );

    typedef struct {
        int         due;
        logic [7:0] d;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_run;
    int          n_fail;
    int          cyc;
    int          wr_count;
    int          wr0;
    int          n_lock;
    logic [15:0] exp_va;
    logic        prev_vgnt;
    logic        prev_locked;
    logic        prev_cr;
    logic        k_vr;
    logic        k_cr;
    logic [1:0]  k_eg;
    logic [7:0]  ram [0:65535];

    bit         tv_vr [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    bit         tv_cr [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0] tv_eg [10] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Synchronous RAM: registered read, write on mem_we.
    always @(posedge clock) begin
        mem_in <= ram[mem_address];
        if (mem_we === 1'b1) begin
            ram[mem_address] = mem_out;
            wr_count++;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        case (a)
            16'h0100: return 8'h11;
            16'h0101: return 8'h22;
            16'h0102: return 8'h33;
            16'h0103: return 8'h44;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every vvalid pulse must match the oldest expected read.
    always @(negedge clock) begin
        if (vvalid !== 1'b0) begin
            if (q.size() == 0) begin
                chk("vvalid_unexpected", 32'(vvalid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("vdata", 32'(vdata), 32'(e.d));
                chk("vvalid_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One clock: fetcher/CPU models advance, inputs are driven, outputs are checked at negedge.
    task automatic cyc_step(input string nm, input logic rn, input logic vr, input logic cr,
                            input logic cw, input logic [1:0] eg, input bit push);
        @(posedge clock);
        #1;
        if (prev_vgnt) vaddr = vaddr + 16'd1;
        if (prev_locked && prev_cr) begin
            cpu_address = cpu_address + 16'd1;
            cpu_out     = cpu_out + 8'd1;
        end
        reset_n = rn;
        vreq    = vr;
        cpu_req = cr;
        cpu_we  = cw;
`ifdef KR580_ARB_STATS_EN
        stall_clr = nxt_clr;
`endif
        @(negedge clock);
        chk({nm, "_gnt"}, 32'({locked, vgnt}), 32'({eg[1], eg[0]}));
        chk({nm, "_we"}, 32'(mem_we), 32'(eg[1] & cw));
        chk({nm, "_addr"}, 32'(mem_address), 32'((eg == 2'b01) ? exp_va : cpu_address));
        chk({nm, "_cpuin"}, 32'(cpu_in), 32'(mem_in));
        if (eg[1] & cw) chk({nm, "_wdata"}, 32'(mem_out), 32'(cpu_out));
        if (!rn) chk({nm, "_vvalid_rst"}, 32'(vvalid), 32'd0);
        if (eg == 2'b01) begin
            if (push) q.push_back('{due: cyc + 2, d: exp_byte(exp_va)});
            exp_va = exp_va + 16'd1;
        end
        prev_vgnt   = vgnt;
        prev_locked = locked;
        prev_cr     = cr;
    endtask

    initial begin
        n_run = 0; n_fail = 0; cyc = 0; wr_count = 0;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; vreq = 1'b0;
        cpu_address = 16'h0000; cpu_out = 8'h00; vaddr = 16'h0000; exp_va = 16'h0000;
        prev_vgnt = 1'b0; prev_locked = 1'b0; prev_cr = 1'b0;
`ifdef KR580_ARB_STATS_EN
        stall_clr = 1'b0; nxt_clr = 1'b0;
`endif
        for (int a = 0; a < 65536; a++) ram[a] = exp_byte(16'(a));

        // Reset state
        cyc_step("rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        cyc_step("rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        chk("rst_vdata", 32'(vdata), 32'd0);
`ifdef KR580_ARB_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // CPU only: write A5 to 1234
        cpu_address = 16'h1234; cpu_out = 8'hA5; wr0 = wr_count;
        cyc_step("cpu_rel",  1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 0);
        cyc_step("cpu_lock", 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 0);
        cyc_step("cpu_tail", 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 0);
        cyc_step("cpu_idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        chk("cpu_ram1234", 32'(ram[16'h1234]), 32'h0000_00A5);
        chk("cpu_wr_count", 32'(wr_count - wr0), 32'd1);

        // Video only: four reads at 0100..0103
        vaddr = 16'h0100; exp_va = 16'h0100;
        cyc_step("vid", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1);
        cyc_step("vid", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1);
        cyc_step("vid", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1);
        cyc_step("vid", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1);
        cyc_step("vid", 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1);
        for (int i = 0; i < 3; i++) cyc_step("vid_idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0);

        // Contention: VVVVC repeating, CPU writes 3000..3003
        vaddr = 16'h0200; exp_va = 16'h0200;
        cpu_address = 16'h3000; cpu_out = 8'hC0; wr0 = wr_count; n_lock = 0;
        for (int k = 0; k <= 22; k++) begin
            k_vr = (k <= 19);
            k_cr = (k <= 20);
            if (k == 0 || k == 22)  k_eg = 2'b00;
            else if (k == 21)       k_eg = 2'b10;
            else if (k % 5 == 0)    k_eg = 2'b10;
            else                    k_eg = 2'b01;
            cyc_step("cont", 1'b1, k_vr, k_cr, k_cr, k_eg, 1);
            if (k >= 1 && k <= 20 && prev_locked) n_lock++;
        end
        chk("cont_locked_count", 32'(n_lock), 32'd4);
        chk("cont_wr_count", 32'(wr_count - wr0), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("cont_ram", 32'(ram[16'h3000 + 16'(i)]), 32'(8'hC0 + 8'(i)));

        // Tie at run start, vreq dropping mid-run clears the run count
        vaddr = 16'h0300; exp_va = 16'h0300; cpu_address = 16'h4000; cpu_out = 8'h00;
        for (int k = 0; k < 10; k++)
            cyc_step("tie", 1'b1, tv_vr[k], tv_cr[k], 1'b0, tv_eg[k], 1);

        // Reset one cycle after a grant
        vaddr = 16'h0500; exp_va = 16'h0500; cpu_address = 16'h5000; wr0 = wr_count;
        cyc_step("rmid",     1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 0);
        cyc_step("rmid",     1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 0);
        cyc_step("rmid_rst", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 0);
        cyc_step("rmid_rst", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 0);
        chk("rmid_no_write", 32'(wr_count - wr0), 32'd0);
        cyc_step("rmid_rel", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 0);
        cyc_step("rmid_cpu", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 0);
        cyc_step("rmid_cpu", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 0);
        cyc_step("rmid_vid", 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1);
        for (int i = 0; i < 3; i++) cyc_step("rmid_idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0);

`ifdef KR580_ARB_STATS_EN
        // Three stalled CPU cycles, then a clear
        vaddr = 16'h0400; exp_va = 16'h0400;
        nxt_clr = 1'b1;
        cyc_step("stat", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1);
        nxt_clr = 1'b0;
        cyc_step("stat", 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1);
        cyc_step("stat", 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1);
        cyc_step("stat", 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1);
        nxt_clr = 1'b1;
        cyc_step("stat", 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1);
        chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
        nxt_clr = 1'b0;
        cyc_step("stat", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1);
        chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 3; i++) cyc_step("stat_idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0);
`endif

        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
